// File: rtl/mp_regfile_pkg.sv
// rtl/mp_regfile_pkg.sv - shared defaults and half-mask helper for the MPU register file
// Register file geometry defaults and the half-select mask used by writes, reads and scoreboard.
package mp_regfile_pkg;

   localparam int HW_DEF  = 16;
   localparam int AW_DEF  = 5;
   localparam int NRD_DEF = 2;
   localparam int NROW    = 2 ** (AW_DEF - 1);

   // bit 0 = low half of the row, bit 1 = high half
   function automatic logic [1:0] half_mask(input logic wide, input logic addr_lsb);
      if (wide) begin
         return 2'b11;
      end
      return addr_lsb ? 2'b10 : 2'b01;
   endfunction

endpackage

// File: rtl/mp_regfile_sb_if.sv
// rtl/mp_regfile_sb_if.sv - decoder/writeback/scoreboard bundle for mp_regfile_sb
// master drives reads, writeback and scoreboard issue; slave is the register file.
interface mp_regfile_sb_if
   import mp_regfile_pkg::*;
#(
   parameter int HW  = HW_DEF,
   parameter int AW  = AW_DEF,
   parameter int NRD = NRD_DEF
);
   logic                  stall;
   logic [NRD*AW-1:0]     rd_addr;
   logic [NRD-1:0]        rd_wide;
   logic [NRD*2*HW-1:0]   rd_data;
   logic [NRD-1:0]        rd_hazard;
   logic                  wb;
   logic                  wb32;
   logic [AW-1:0]         wb_rd;
   logic [2*HW-1:0]       wb_data;
   logic                  sb_set;
   logic                  sb_set32;
   logic [AW-1:0]         sb_rd;
   logic                  sb_any;

   modport master (
      output stall, rd_addr, rd_wide, wb, wb32, wb_rd, wb_data, sb_set, sb_set32, sb_rd,
      input  rd_data, rd_hazard, sb_any
   );

   modport slave (
      input  stall, rd_addr, rd_wide, wb, wb32, wb_rd, wb_data, sb_set, sb_set32, sb_rd,
      output rd_data, rd_hazard, sb_any
   );
endinterface

// File: rtl/mp_regfile_bank.sv
// rtl/mp_regfile_bank.sv - half-masked single-write, multi-async-read storage array
// Each row is two independently writable halves; storage is intentionally not reset.
module mp_regfile_bank #(
   parameter int HW  = 16,
   parameter int AW  = 5,
   parameter int NRD = 2
) (
   input  logic                    clk,
   input  logic [1:0]              i_we_mask,
   input  logic [AW-2:0]           i_wrow,
   input  logic [2*HW-1:0]         i_wdata,
   input  logic [NRD*(AW-1)-1:0]   i_rrow,
   output logic [NRD*2*HW-1:0]     o_rdata
);
   localparam int NR = 2 ** (AW - 1);
   localparam int RW = AW - 1;

   logic [HW-1:0] r_lo [NR];
   logic [HW-1:0] r_hi [NR];

   always_ff @(posedge clk) begin
      if (i_we_mask[0]) begin
         r_lo[i_wrow] <= i_wdata[HW-1:0];
      end
      if (i_we_mask[1]) begin
         r_hi[i_wrow] <= i_wdata[2*HW-1:HW];
      end
   end

   for (genvar g = 0; g < NRD; g++) begin : g_rd
      logic [RW-1:0] w_row;
      assign w_row = i_rrow[g*RW +: RW];
      assign o_rdata[g*2*HW +: 2*HW] = {r_hi[w_row], r_lo[w_row]};
   end

endmodule

// File: rtl/mp_regfile_sb.sv
// rtl/mp_regfile_sb.sv - MPU register file with write-through bypass, zero r0 and half scoreboard
// Storage lives in mp_regfile_bank; this level adds bypass, zero mux and pending-write tracking.
module mp_regfile_sb
   import mp_regfile_pkg::*;
#(
   parameter int HW      = HW_DEF,
   parameter int AW      = AW_DEF,
   parameter int NRD     = NRD_DEF,
   parameter int ZERO_R0 = 1
) (
   input  logic           clk,
   input  logic           sys_rst,
   mp_regfile_sb_if.slave bus
);
   localparam int NH = 2 ** AW;
   localparam int RW = AW - 1;

   logic [RW-1:0]         w_wb_row;
   logic [RW-1:0]         w_sb_row;
   logic                  w_wb_zero;
   logic                  w_sb_zero;
   logic [1:0]            w_wb_mask;
   logic [1:0]            w_sb_mask;
   logic [2*HW-1:0]       w_wb_data;
   logic [NH-1:0]         w_written;
   logic [NH-1:0]         w_set;
   logic [NH-1:0]         r_sb;
   logic [NRD*RW-1:0]     w_rrow;
   logic [NRD*2*HW-1:0]   w_arr_data;

   assign w_wb_row  = bus.wb_rd[AW-1:1];
   assign w_sb_row  = bus.sb_rd[AW-1:1];
   assign w_wb_zero = (ZERO_R0 != 0) && (w_wb_row == '0);
   assign w_sb_zero = (ZERO_R0 != 0) && (w_sb_row == '0);
   assign w_wb_mask = (bus.wb && !w_wb_zero) ? half_mask(bus.wb32, bus.wb_rd[0]) : 2'b00;
   assign w_sb_mask = (bus.sb_set && !bus.stall && !w_sb_zero)
                      ? half_mask(bus.sb_set32, bus.sb_rd[0]) : 2'b00;
   assign w_wb_data = bus.wb32 ? bus.wb_data : {2{bus.wb_data[HW-1:0]}};

   always_comb begin
      w_written = '0;
      w_set     = '0;
      w_written[{w_wb_row, 1'b0}] = w_wb_mask[0];
      w_written[{w_wb_row, 1'b1}] = w_wb_mask[1];
      w_set[{w_sb_row, 1'b0}]     = w_sb_mask[0];
      w_set[{w_sb_row, 1'b1}]     = w_sb_mask[1];
   end

   // set after clear: a fresh issue to a half that is completing this cycle stays pending
   always_ff @(posedge clk or posedge sys_rst) begin
      if (sys_rst) begin
         r_sb <= '0;
      end else begin
         r_sb <= (r_sb & ~w_written) | w_set;
      end
   end

   assign bus.sb_any = |r_sb;

   mp_regfile_bank #(
      .HW  (HW),
      .AW  (AW),
      .NRD (NRD)
   ) u_bank (
      .clk       (clk),
      .i_we_mask (w_wb_mask),
      .i_wrow    (w_wb_row),
      .i_wdata   (w_wb_data),
      .i_rrow    (w_rrow),
      .o_rdata   (w_arr_data)
   );

   for (genvar g = 0; g < NRD; g++) begin : g_port
      logic [AW-1:0]   w_addr;
      logic [RW-1:0]   w_row;
      logic [1:0]      w_rmask;
      logic [1:0]      w_byp;
      logic [1:0]      w_pend;
      logic [1:0]      w_wr;
      logic [HW-1:0]   w_lo;
      logic [HW-1:0]   w_hi;
      logic [2*HW-1:0] w_arr;
      logic [2*HW-1:0] w_mux;

      assign w_addr  = bus.rd_addr[g*AW +: AW];
      assign w_row   = w_addr[AW-1:1];
      assign w_rrow[g*RW +: RW] = w_row;
      assign w_arr   = w_arr_data[g*2*HW +: 2*HW];
      assign w_rmask = half_mask(bus.rd_wide[g], w_addr[0]);

      assign w_byp = (w_row == w_wb_row) ? w_wb_mask : 2'b00;
      assign w_lo  = w_byp[0] ? w_wb_data[HW-1:0]    : w_arr[HW-1:0];
      assign w_hi  = w_byp[1] ? w_wb_data[2*HW-1:HW] : w_arr[2*HW-1:HW];
      assign w_mux = bus.rd_wide[g] ? {w_hi, w_lo}
                                    : {{HW{1'b0}}, (w_addr[0] ? w_hi : w_lo)};
      assign bus.rd_data[g*2*HW +: 2*HW] = ((ZERO_R0 != 0) && (w_row == '0)) ? '0 : w_mux;

      assign w_pend = {r_sb[{w_row, 1'b1}], r_sb[{w_row, 1'b0}]};
      assign w_wr   = {w_written[{w_row, 1'b1}], w_written[{w_row, 1'b0}]};
      assign bus.rd_hazard[g] = |(w_rmask & w_pend & ~w_wr);
   end

endmodule

// File: tb/tb_mp_regfile_sb.sv
// tb/tb_mp_regfile_sb.sv - directed self-checking bench for mp_regfile_sb
// Inputs change 1ns after posedge; outputs are sampled mid-cycle.
module tb_mp_regfile_sb;

   logic clk = 1'b0;
   logic sys_rst;
   int   checks = 0;
   int   errors = 0;

   always #5 clk = ~clk;

   mp_regfile_sb_if #(.HW(16), .AW(5), .NRD(2)) bus ();

   mp_regfile_sb #(.HW(16), .AW(5), .NRD(2), .ZERO_R0(1)) dut (
      .clk     (clk),
      .sys_rst (sys_rst),
      .bus     (bus)
   );

   function automatic logic [31:0] pdata(input int p);
      return bus.rd_data[p*32 +: 32];
   endfunction

   task automatic idle();
      bus.stall = 1'b0; bus.wb = 1'b0; bus.wb32 = 1'b0; bus.wb_rd = '0; bus.wb_data = '0;
      bus.sb_set = 1'b0; bus.sb_set32 = 1'b0; bus.sb_rd = '0;
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic rd(input int p, input logic [4:0] a, input logic w);
      bus.rd_addr[p*5 +: 5] = a;
      bus.rd_wide[p]        = w;
   endtask

   task automatic wr(input logic [4:0] a, input logic w32, input logic [31:0] d);
      bus.wb = 1'b1; bus.wb32 = w32; bus.wb_rd = a; bus.wb_data = d;
   endtask

   task automatic test_reset();
      sys_rst = 1'b1;
      idle();
      bus.rd_addr = '0; bus.rd_wide = '0;
      rd(0, 5'd0, 1'b1); rd(1, 5'd9, 1'b0);
      #2;
      checks++; if (bus.sb_any !== 1'b0) begin errors++; $display("FAIL reset_sb_any: got %b want 0", bus.sb_any); end
      checks++; if (bus.rd_hazard !== 2'b00) begin errors++; $display("FAIL reset_hazard: got %b want 00", bus.rd_hazard); end
      checks++; if (pdata(0) !== 32'h0) begin errors++; $display("FAIL reset_r0: got %h want 00000000", pdata(0)); end
      bus.sb_set = 1'b1; bus.sb_rd = 5'd9;
      step();
      #1;
      checks++; if (bus.sb_any !== 1'b0) begin errors++; $display("FAIL reset_hold_sb: got %b want 0", bus.sb_any); end
      sys_rst = 1'b0;
      idle();
      step();
   endtask

   task automatic test_half_write();
      logic [31:0] v;
      wr(5'd5, 1'b0, 32'h0000_BEEF); rd(0, 5'd5, 1'b0); rd(1, 5'd4, 1'b1);
      #2;
      checks++; if (pdata(0) !== 32'h0000_BEEF) begin errors++; $display("FAIL half_bypass: got %h want 0000beef", pdata(0)); end
      v = pdata(1);
      checks++; if (v[31:16] !== 16'hBEEF) begin errors++; $display("FAIL half_bypass_wide_hi: got %h want beef", v[31:16]); end
      step();
      idle(); rd(0, 5'd4, 1'b1); rd(1, 5'd5, 1'b0);
      #2;
      v = pdata(0);
      checks++; if (v[31:16] !== 16'hBEEF) begin errors++; $display("FAIL half_array_wide_hi: got %h want beef", v[31:16]); end
      checks++; if (pdata(1) !== 32'h0000_BEEF) begin errors++; $display("FAIL half_array: got %h want 0000beef", pdata(1)); end
      step();
   endtask

   task automatic test_wide_bypass();
      wr(5'd6, 1'b1, 32'h1234_5678); rd(0, 5'd6, 1'b1); rd(1, 5'd7, 1'b0);
      #2;
      checks++; if (pdata(1) !== 32'h0000_1234) begin errors++; $display("FAIL wide_byp_hi_half: got %h want 00001234", pdata(1)); end
      checks++; if (pdata(0) !== 32'h1234_5678) begin errors++; $display("FAIL wide_byp_wide: got %h want 12345678", pdata(0)); end
      step();
      idle();
      #2;
      checks++; if (pdata(1) !== 32'h0000_1234) begin errors++; $display("FAIL wide_arr_hi_half: got %h want 00001234", pdata(1)); end
      checks++; if (pdata(0) !== 32'h1234_5678) begin errors++; $display("FAIL wide_arr_wide: got %h want 12345678", pdata(0)); end
      wr(5'd7, 1'b0, 32'hFFFF_AAAA);
      #1;
      checks++; if (pdata(0) !== 32'hAAAA_5678) begin errors++; $display("FAIL mixed_byp: got %h want aaaa5678", pdata(0)); end
      checks++; if (pdata(1) !== 32'h0000_AAAA) begin errors++; $display("FAIL mixed_byp_half: got %h want 0000aaaa", pdata(1)); end
      step();
      idle();
      #2;
      checks++; if (pdata(0) !== 32'hAAAA_5678) begin errors++; $display("FAIL mixed_arr: got %h want aaaa5678", pdata(0)); end
      step();
   endtask

   task automatic test_zero_r0();
      wr(5'd0, 1'b1, 32'hFFFF_FFFF);
      bus.sb_set = 1'b1; bus.sb_set32 = 1'b1; bus.sb_rd = 5'd0;
      rd(0, 5'd0, 1'b1); rd(1, 5'd1, 1'b0);
      #2;
      checks++; if (pdata(0) !== 32'h0) begin errors++; $display("FAIL r0_byp_wide: got %h want 00000000", pdata(0)); end
      checks++; if (pdata(1) !== 32'h0) begin errors++; $display("FAIL r0_byp_half: got %h want 00000000", pdata(1)); end
      step();
      idle();
      #2;
      checks++; if (pdata(0) !== 32'h0) begin errors++; $display("FAIL r0_arr_wide: got %h want 00000000", pdata(0)); end
      checks++; if (bus.sb_any !== 1'b0) begin errors++; $display("FAIL r0_sb_any: got %b want 0", bus.sb_any); end
      checks++; if (bus.rd_hazard !== 2'b00) begin errors++; $display("FAIL r0_hazard: got %b want 00", bus.rd_hazard); end
      step();
   endtask

   task automatic test_scoreboard();
      bus.sb_set = 1'b1; bus.sb_rd = 5'd9; rd(0, 5'd9, 1'b0); rd(1, 5'd8, 1'b0);
      #2;
      checks++; if (bus.rd_hazard[0] !== 1'b0) begin errors++; $display("FAIL sb_same_cycle: got %b want 0", bus.rd_hazard[0]); end
      step();
      idle();
      #2;
      checks++; if (bus.rd_hazard !== 2'b01) begin errors++; $display("FAIL sb_hazard_half: got %b want 01", bus.rd_hazard); end
      checks++; if (bus.sb_any !== 1'b1) begin errors++; $display("FAIL sb_any_set: got %b want 1", bus.sb_any); end
      rd(1, 5'd8, 1'b1);
      #1;
      checks++; if (bus.rd_hazard[1] !== 1'b1) begin errors++; $display("FAIL sb_hazard_wide: got %b want 1", bus.rd_hazard[1]); end
      step();
      wr(5'd9, 1'b0, 32'h0000_0077); rd(0, 5'd9, 1'b0);
      #2;
      checks++; if (bus.rd_hazard !== 2'b00) begin errors++; $display("FAIL sb_release: got %b want 00", bus.rd_hazard); end
      checks++; if (pdata(0) !== 32'h0000_0077) begin errors++; $display("FAIL sb_release_data: got %h want 00000077", pdata(0)); end
      step();
      idle();
      #2;
      checks++; if (bus.rd_hazard[0] !== 1'b0) begin errors++; $display("FAIL sb_cleared_hazard: got %b want 0", bus.rd_hazard[0]); end
      checks++; if (bus.sb_any !== 1'b0) begin errors++; $display("FAIL sb_cleared_any: got %b want 0", bus.sb_any); end
      step();
   endtask

   task automatic test_set_clear_same();
      bus.sb_set = 1'b1; bus.sb_rd = 5'd12; wr(5'd12, 1'b0, 32'h1);
      step();
      idle(); rd(0, 5'd12, 1'b0);
      #2;
      checks++; if (bus.sb_any !== 1'b1) begin errors++; $display("FAIL set_wins_any: got %b want 1", bus.sb_any); end
      checks++; if (bus.rd_hazard[0] !== 1'b1) begin errors++; $display("FAIL set_wins_hazard: got %b want 1", bus.rd_hazard[0]); end
      wr(5'd12, 1'b0, 32'h2);
      step();
      idle();
      #2;
      checks++; if (bus.sb_any !== 1'b0) begin errors++; $display("FAIL set_wins_cleared: got %b want 0", bus.sb_any); end
      bus.stall = 1'b1; bus.sb_set = 1'b1; bus.sb_rd = 5'd14;
      step();
      idle(); rd(0, 5'd14, 1'b0);
      #2;
      checks++; if (bus.sb_any !== 1'b0) begin errors++; $display("FAIL stall_blocks_any: got %b want 0", bus.sb_any); end
      checks++; if (bus.rd_hazard[0] !== 1'b0) begin errors++; $display("FAIL stall_blocks_hazard: got %b want 0", bus.rd_hazard[0]); end
      step();
   endtask

   task automatic test_set32();
      bus.sb_set = 1'b1; bus.sb_set32 = 1'b1; bus.sb_rd = 5'd21;
      step();
      idle(); rd(0, 5'd20, 1'b0); rd(1, 5'd21, 1'b0);
      #2;
      checks++; if (bus.rd_hazard !== 2'b11) begin errors++; $display("FAIL set32_hazard: got %b want 11", bus.rd_hazard); end
      wr(5'd20, 1'b1, 32'hDEAD_0001);
      #1;
      checks++; if (bus.rd_hazard !== 2'b00) begin errors++; $display("FAIL set32_release: got %b want 00", bus.rd_hazard); end
      checks++; if (pdata(1) !== 32'h0000_DEAD) begin errors++; $display("FAIL set32_data: got %h want 0000dead", pdata(1)); end
      step();
      idle();
      #2;
      checks++; if (bus.sb_any !== 1'b0) begin errors++; $display("FAIL set32_cleared: got %b want 0", bus.sb_any); end
      step();
   endtask

   task automatic test_reset_mid();
      bus.sb_set = 1'b1; bus.sb_set32 = 1'b1; bus.sb_rd = 5'd2;
      step();
      bus.sb_set32 = 1'b0; bus.sb_rd = 5'd10;
      step();
      idle(); rd(0, 5'd3, 1'b0); rd(1, 5'd10, 1'b0);
      #2;
      checks++; if (bus.sb_any !== 1'b1) begin errors++; $display("FAIL mid_pre_any: got %b want 1", bus.sb_any); end
      checks++; if (bus.rd_hazard !== 2'b11) begin errors++; $display("FAIL mid_pre_hazard: got %b want 11", bus.rd_hazard); end
      sys_rst = 1'b1;
      #1;
      checks++; if (bus.sb_any !== 1'b0) begin errors++; $display("FAIL mid_rst_any: got %b want 0", bus.sb_any); end
      checks++; if (bus.rd_hazard !== 2'b00) begin errors++; $display("FAIL mid_rst_hazard: got %b want 00", bus.rd_hazard); end
      #1;
      sys_rst = 1'b0;
      step();
      wr(5'd10, 1'b0, 32'h0000_CAFE);
      step();
      idle(); rd(1, 5'd10, 1'b0);
      #2;
      checks++; if (pdata(1) !== 32'h0000_CAFE) begin errors++; $display("FAIL mid_post_data: got %h want 0000cafe", pdata(1)); end
      checks++; if (bus.sb_any !== 1'b0) begin errors++; $display("FAIL mid_post_any: got %b want 0", bus.sb_any); end
      step();
   endtask

   initial begin
      test_reset();
      test_half_write();
      test_wide_bypass();
      test_zero_r0();
      test_scoreboard();
      test_set_clear_same();
      test_set32();
      test_reset_mid();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
